// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU with a shared ripple adder and a shift-add multiplier
module alu_seq #(
    parameter int MUL_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] Op,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] R,
    output logic       Carry,
    output logic       V,
    output logic       Err
);
    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    state_t     state, state_nx;
    logic [3:0] a_r, b_r, op_r, hi, lo;
    logic [1:0] cnt;
    logic [3:0] ax, ay, s, hs;
    logic       cin, c3, c4, hc;
    logic       accept, is_alu, is_mul, sub, is_add, is_lt, is_gt;
    logic       ov, lt;
    logic [7:0] r_exec;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign is_alu    = (Op == 4'b0010) || (Op == 4'b0110) || (Op == 4'b0111) || (Op == 4'b1111);
    assign is_mul    = (Op == 4'b1000) && (MUL_EN != 0);

    assign is_add = (op_r == 4'b0010);
    assign is_lt  = (op_r == 4'b0111);
    assign is_gt  = (op_r == 4'b1111);
    assign sub    = !is_add;

    // The single adder: multiply accumulates hi + A, otherwise A + (B or ~B) + cin
    assign ax  = (state == MUL) ? hi : a_r;
    assign ay  = (state == MUL) ? a_r : (sub ? ~b_r : b_r);
    assign cin = (state != MUL) && sub;

    // Ripple-carry chain, also exposing the carry into bit 3 for overflow
    always_comb begin
        logic c;
        c  = cin;
        c3 = 1'b0;
        s  = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) c3 = c;
            s[i] = ax[i] ^ ay[i] ^ c;
            c    = (ax[i] & ay[i]) | (c & (ax[i] ^ ay[i]));
        end
        c4 = c;
    end

    assign ov     = c3 ^ c4;
    assign lt     = s[3] ^ ov;
    assign r_exec = is_lt ? {7'd0, lt} : is_gt ? {7'd0, ~lt & (s != 4'd0)} : {4'd0, s};
    assign hs     = lo[0] ? s : hi;
    assign hc     = lo[0] & c4;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state selection
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = is_mul ? MUL : is_alu ? EXEC : DONE;
            EXEC: state_nx = DONE;
            MUL:  if (cnt == 2'd3) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, multiply iteration and result/flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            R     <= 8'd0;
            Carry <= 1'b0;
            V     <= 1'b0;
            Err   <= 1'b0;
            cnt   <= 2'd0;
        end else begin
            if (accept) begin
                a_r  <= A;
                b_r  <= B;
                op_r <= Op;
                hi   <= 4'd0;
                lo   <= B;
                cnt  <= 2'd0;
                if (!is_alu && !is_mul) begin
                    R     <= 8'd0;
                    Carry <= 1'b0;
                    V     <= 1'b0;
                    Err   <= 1'b1;
                end
            end
            if (state == EXEC) begin
                R     <= r_exec;
                Carry <= (is_lt || is_gt) ? 1'b0 : c4;
                V     <= (is_lt || is_gt) ? 1'b0 : ov;
                Err   <= 1'b0;
            end
            if (state == MUL) begin
                hi  <= {hc, hs[3:1]};
                lo  <= {hs[0], lo[3:1]};
                cnt <= cnt + 2'd1;
                if (cnt == 2'd3) begin
                    R     <= {hc, hs[3:1], hs[0], lo[3:1]};
                    Carry <= 1'b0;
                    V     <= 1'b0;
                    Err   <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq
module tb_alu_seq;
    logic       clk = 1'b0;
    logic       rst, in_valid, out_ready, in_valid0, out_ready0;
    logic [3:0] A, B, Op;
    logic       in_ready, out_valid, Carry, V, Err;
    logic       in_ready0, out_valid0, Carry0, V0, Err0;
    logic [7:0] R, R0;
    int         checks = 0;
    int         errors = 0;

    alu_seq #(.MUL_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Op(Op), .out_valid(out_valid), .out_ready(out_ready),
        .R(R), .Carry(Carry), .V(V), .Err(Err)
    );

    alu_seq #(.MUL_EN(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .A(A), .B(B), .Op(Op), .out_valid(out_valid0), .out_ready(out_ready0),
        .R(R0), .Carry(Carry0), .V(V0), .Err(Err0)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                       input int lat, input logic [7:0] er, input logic ec, input logic ev, input logic ee);
        int n;
        A = a; B = b; Op = op; in_valid = 1'b1; out_ready = 1'b0;
        chk({tag, " ready"}, {31'd0, in_ready}, 32'd1);
        tick;
        in_valid = 1'b0; A = ~a; B = ~b; Op = 4'b0010;
        n = 1;
        while (!out_valid && n < 20) begin
            chk({tag, " busy"}, {31'd0, in_ready}, 32'd0);
            tick;
            n++;
        end
        chk({tag, " latency"}, n, lat);
        chk({tag, " R"}, {24'd0, R}, {24'd0, er});
        chk({tag, " Carry"}, {31'd0, Carry}, {31'd0, ec});
        chk({tag, " V"}, {31'd0, V}, {31'd0, ev});
        chk({tag, " Err"}, {31'd0, Err}, {31'd0, ee});
        for (int i = 0; i < 3; i++) begin
            tick;
            chk({tag, " hold R"}, {24'd0, R}, {24'd0, er});
            chk({tag, " hold valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, " hold ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk({tag, " ready after"}, {31'd0, in_ready}, 32'd1);
        chk({tag, " valid after"}, {31'd0, out_valid}, 32'd0);
        chk({tag, " R kept"}, {24'd0, R}, {24'd0, er});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0;
        A = 4'd0; B = 4'd0; Op = 4'd0;
        tick;
        tick;
        chk("ready in reset", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("reset ready", {31'd0, in_ready}, 32'd1);
        chk("reset valid", {31'd0, out_valid}, 32'd0);
        chk("reset R", {24'd0, R}, 32'd0);
        chk("reset flags", {29'd0, Carry, V, Err}, 32'd0);

        run("ADD 7+1", 4'b0111, 4'b0001, 4'b0010, 2, 8'h08, 1'b0, 1'b1, 1'b0);
        run("ADD F+1", 4'b1111, 4'b0001, 4'b0010, 2, 8'h00, 1'b1, 1'b0, 1'b0);
        run("SUB 3-5", 4'b0011, 4'b0101, 4'b0110, 2, 8'h0E, 1'b0, 1'b0, 1'b0);
        run("SUB 8-1", 4'b1000, 4'b0001, 4'b0110, 2, 8'h07, 1'b1, 1'b1, 1'b0);
        run("LT -1<1", 4'b1111, 4'b0001, 4'b0111, 2, 8'h01, 1'b0, 1'b0, 1'b0);
        run("GT -1>1", 4'b1111, 4'b0001, 4'b1111, 2, 8'h00, 1'b0, 1'b0, 1'b0);
        run("GT 5>5", 4'b0101, 4'b0101, 4'b1111, 2, 8'h00, 1'b0, 1'b0, 1'b0);
        run("GT 3>-2", 4'b0011, 4'b1110, 4'b1111, 2, 8'h01, 1'b0, 1'b0, 1'b0);
        run("MUL F*F", 4'b1111, 4'b1111, 4'b1000, 5, 8'hE1, 1'b0, 1'b0, 1'b0);
        run("MUL 9*7", 4'b1001, 4'b0111, 4'b1000, 5, 8'h3F, 1'b0, 1'b0, 1'b0);
        run("ILLEGAL", 4'b0101, 4'b0011, 4'b0001, 1, 8'h00, 1'b0, 1'b0, 1'b1);
        run("ADD after err", 4'b0010, 4'b0011, 4'b0010, 2, 8'h05, 1'b0, 1'b0, 1'b0);

        A = 4'b0011; B = 4'b0101; Op = 4'b1000; in_valid0 = 1'b1;
        tick;
        in_valid0 = 1'b0;
        chk("nomul valid", {31'd0, out_valid0}, 32'd1);
        chk("nomul Err", {31'd0, Err0}, 32'd1);
        chk("nomul R", {24'd0, R0}, 32'd0);
        out_ready0 = 1'b1;
        tick;
        out_ready0 = 1'b0;
        chk("nomul ready after", {31'd0, in_ready0}, 32'd1);

        A = 4'b1111; B = 4'b1111; Op = 4'b1000; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        #1;
        chk("ready during rst", {31'd0, in_ready}, 32'd0);
        tick;
        rst = 1'b0;
        #1;
        chk("rst mid-MUL ready", {31'd0, in_ready}, 32'd1);
        chk("rst mid-MUL valid", {31'd0, out_valid}, 32'd0);
        chk("rst mid-MUL R", {24'd0, R}, 32'd0);
        tick;
        tick;
        chk("no stale valid", {31'd0, out_valid}, 32'd0);
        run("ADD after rst", 4'b0100, 4'b0101, 4'b0010, 2, 8'h09, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
